// File: rtl/serial_pattern_source.sv
// ---------------------------------------------------------------------------
// serial_pattern_source
//
// Parallel-to-serial stage feeding the single-bit input of the Mealy pattern
// detector. Words of WIDTH bits arrive over a valid/ready handshake and are
// shifted out one bit per clock. A one-word holding buffer lets a second
// word wait behind the one being shifted, so consecutive words stream with
// no idle cycle between them. When no word is being shifted the line sits
// at IDLE_LEVEL. Every fully shifted word is counted in words_sent.
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: in_data[WIDTH-1] goes out first, 0: in_data[0] goes first
//   IDLE_LEVEL level driven on serial_out while nothing is being shifted
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous, active-low reset
//   in_data        word to serialise
//   in_valid       in_data is valid
//   in_ready       block can accept a word this cycle (holding buffer empty)
//   serial_out     registered serial bit stream (detector input i)
//   serial_active  registered, 1 while serial_out carries a data bit
//   words_sent     count of completed words, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module serial_pattern_source #(
    parameter int WIDTH      = 9,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_active,
    output logic [15:0]      words_sent
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  shifter, shifter_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic [WIDTH-1:0]  hold_data, hold_data_next;
    logic              hold_valid, hold_valid_next;
    logic              serial_out_next;
    logic              serial_active_next;
    logic [15:0]       words_sent_next;
    logic              accept;

    // The bit that goes on the line first for a given word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST)
            return w[WIDTH-1];
        else
            return w[0];
    endfunction

    // The word with its first-out bit removed, so the next bit to send
    // always sits at the same end of the shifter.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        if (MSB_FIRST)
            return {w[WIDTH-2:0], 1'b0};
        else
            return {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready depends only on the holding buffer, never on in_valid, so the
    // upstream source sees no combinational loop through this block.
    assign in_ready = ~hold_valid;
    assign accept   = in_valid & ~hold_valid;

    // State and datapath registers. Reset discards both the in-flight word
    // and any held word and returns the line to idle straight away.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            shifter       <= '0;
            cnt           <= '0;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            serial_out    <= IDLE_LEVEL;
            serial_active <= 1'b0;
            words_sent    <= '0;
        end else begin
            state         <= state_next;
            shifter       <= shifter_next;
            cnt           <= cnt_next;
            hold_data     <= hold_data_next;
            hold_valid    <= hold_valid_next;
            serial_out    <= serial_out_next;
            serial_active <= serial_active_next;
            words_sent    <= words_sent_next;
        end
    end

    // Next-state and next-output logic. The shifter always holds the bits
    // that are still to be sent after the one currently on the line; the
    // line bit itself lives in the serial_out register. At the end of a word
    // the held word takes priority over a new arrival, and a new arrival on
    // that edge can only bypass the holding buffer when the buffer is empty,
    // so the shifter and the buffer never both take in_data on one edge.
    always_comb begin
        state_next         = state;
        shifter_next       = shifter;
        cnt_next           = cnt;
        hold_data_next     = hold_data;
        hold_valid_next    = hold_valid;
        serial_out_next    = serial_out;
        serial_active_next = serial_active;
        words_sent_next    = words_sent;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    shifter_next       = shift_once(in_data);
                    serial_out_next    = first_bit(in_data);
                    serial_active_next = 1'b1;
                    cnt_next           = '0;
                    state_next         = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt != LAST_BIT) begin
                    cnt_next        = cnt + CW'(1);
                    serial_out_next = first_bit(shifter);
                    shifter_next    = shift_once(shifter);
                    if (accept) begin
                        hold_data_next  = in_data;
                        hold_valid_next = 1'b1;
                    end
                end else begin
                    words_sent_next = words_sent + 16'd1;
                    if (hold_valid) begin
                        shifter_next       = shift_once(hold_data);
                        serial_out_next    = first_bit(hold_data);
                        serial_active_next = 1'b1;
                        cnt_next           = '0;
                        hold_valid_next    = 1'b0;
                    end else if (accept) begin
                        shifter_next       = shift_once(in_data);
                        serial_out_next    = first_bit(in_data);
                        serial_active_next = 1'b1;
                        cnt_next           = '0;
                    end else begin
                        serial_out_next    = IDLE_LEVEL;
                        serial_active_next = 1'b0;
                        cnt_next           = '0;
                        state_next         = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_source.sv
// ---------------------------------------------------------------------------
// tb_serial_pattern_source
//
// Drives one MSB-first and one LSB-first instance of serial_pattern_source
// with identical handshake traffic and compares every output against a
// word-queue reference model after each clock.
// ---------------------------------------------------------------------------
module tb_serial_pattern_source;

    localparam int W = 9;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] inData;
    logic         inValid;

    logic         readyM, outM, actM;
    logic [15:0]  wsM;
    logic         readyL, outL, actL;
    logic [15:0]  wsL;

    int total = 0;
    int bad   = 0;

    // Reference model: words accepted but not yet completed, the position
    // of the bit on the line within the front word, and the completion count.
    logic [W-1:0] wordQ[$];
    int           pos;
    bit           active;
    logic [15:0]  sentModel;

    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dutM (
        .clock(clock), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
        .in_ready(readyM), .serial_out(outM), .serial_active(actM), .words_sent(wsM)
    );

    serial_pattern_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dutL (
        .clock(clock), .reset_n(reset_n), .in_data(inData), .in_valid(inValid),
        .in_ready(readyL), .serial_out(outL), .serial_active(actL), .words_sent(wsL)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit modelReady();
        return wordQ.size() < 2;
    endfunction

    function automatic logic expBit(input bit msb);
        logic [W-1:0] w;
        if (!active) return 1'b1;
        w = wordQ[0];
        return msb ? w[W-1-pos] : w[pos];
    endfunction

    task automatic modelReset();
        wordQ.delete();
        pos       = 0;
        active    = 0;
        sentModel = 16'd0;
    endtask

    // One rising edge of the model: finish or advance the current word,
    // then take a newly accepted word onto the end of the queue.
    task automatic modelEdge(input bit acc, input logic [W-1:0] d);
        if (active) begin
            if (pos == W - 1) begin
                sentModel = sentModel + 16'd1;
                void'(wordQ.pop_front());
                pos = 0;
                if (wordQ.size() == 0) active = 0;
            end else begin
                pos = pos + 1;
            end
        end
        if (acc) begin
            wordQ.push_back(d);
            if (!active) begin
                active = 1;
                pos    = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        check("msb_ready",  16'(readyM), 16'(modelReady()));
        check("msb_out",    16'(outM),   16'(expBit(1'b1)));
        check("msb_active", 16'(actM),   16'(active));
        check("msb_words",  wsM,         sentModel);
        check("lsb_ready",  16'(readyL), 16'(modelReady()));
        check("lsb_out",    16'(outL),   16'(expBit(1'b0)));
        check("lsb_active", 16'(actL),   16'(active));
        check("lsb_words",  wsL,         sentModel);
    endtask

    // Drive one cycle of handshake traffic, advance the model at the rising
    // edge and check all outputs on the following falling edge.
    task automatic applyStimulus(input bit v, input logic [W-1:0] d);
        bit acc;
        inValid = v;
        inData  = d;
        acc     = v && modelReady();
        @(posedge clock);
        modelEdge(acc, d);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0);
    endtask

    initial begin
        $display("[TB] start");
        modelReset();
        reset_n = 1'b0;
        inValid = 1'b1;
        inData  = 9'b101001101;

        // Reset held for three cycles with in_valid high: nothing accepted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            checkOutput();
        end
        reset_n = 1'b1;
        inValid = 1'b0;
        #1 checkOutput();

        // Single word, then back to idle.
        applyStimulus(1'b1, 9'b101001101);
        idle(11);

        // Back-to-back words; a third word is offered while the buffer is
        // full and must be ignored until it is withdrawn.
        applyStimulus(1'b1, 9'b101001101);
        applyStimulus(1'b1, 9'b010110010);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9'b111100001);
        idle(20);

        // New word offered exactly while the last bit is displayed.
        applyStimulus(1'b1, 9'b110011001);
        idle(8);
        applyStimulus(1'b1, 9'b001100110);
        idle(12);

        // Word with an obvious bit-order signature.
        applyStimulus(1'b1, 9'b000000011);
        idle(11);

        // Reset while bit 4 is on the line and a second word is held.
        applyStimulus(1'b1, 9'b100110101);
        applyStimulus(1'b1, 9'b011001010);
        idle(3);
        #2 reset_n = 1'b0;
        #1 modelReset();
        checkOutput();
        @(posedge clock);
        @(negedge clock);
        checkOutput();
        reset_n = 1'b1;
        idle(12);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom % 3) != 0, W'($urandom));
        idle(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
